// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES round sequencer for encrypt/decrypt, AES-128/192/256, with configurable cycles per round.
module aes_round_ctrl #(
  parameter int CYCLES_PER_ROUND = 3,
  parameter int LAST_CYCLES      = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic       decrypt,
  input  logic [1:0] key_len,
  output logic       busy,
  output logic       done,
  output logic       mux_sel,
  output logic       mix_en,
  output logic       last_round,
  output logic       req_key,
  output logic [3:0] round_idx
);
  typedef enum logic [1:0] {IDLE, INIT, MID, LAST} state_t;
  localparam logic [2:0] MID_TOP  = 3'(CYCLES_PER_ROUND - 1);
  localparam logic [2:0] LAST_TOP = 3'(LAST_CYCLES - 1);
  state_t     state, state_n;
  logic [3:0] r, r_n, nr, nr_n;
  logic [2:0] cnt, cnt_n;
  logic       dec, dec_n;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      r     <= '0;
      cnt   <= '0;
      nr    <= 4'd10;
      dec   <= 1'b0;
    end else begin
      state <= state_n;
      r     <= r_n;
      cnt   <= cnt_n;
      nr    <= nr_n;
      dec   <= dec_n;
    end
  always_comb begin
    state_n = state;
    r_n     = r;
    cnt_n   = cnt;
    nr_n    = nr;
    dec_n   = dec;
    case (state)
      IDLE: if (start && !abort) begin
        state_n = INIT;
        dec_n   = decrypt;
        nr_n    = key_len == 2'b01 ? 4'd12 : key_len == 2'b10 ? 4'd14 : 4'd10;
      end
      INIT: begin
        state_n = MID;
        r_n     = 4'd1;
        cnt_n   = MID_TOP;
      end
      MID: if (cnt != 3'd0) cnt_n = cnt - 3'd1;
        else if (r == nr - 4'd1) begin
          state_n = LAST;
          cnt_n   = LAST_TOP;
        end else begin
          r_n   = r + 4'd1;
          cnt_n = MID_TOP;
        end
      default: if (cnt != 3'd0) cnt_n = cnt - 3'd1;
        else begin
          state_n = IDLE;
          r_n     = '0;
        end
    endcase
    // abort outranks every transition out of a busy state, including the done cycle
    if (abort && state != IDLE) begin
      state_n = IDLE;
      r_n     = '0;
      cnt_n   = '0;
    end
  end
  always_comb begin
    busy       = state != IDLE;
    mux_sel    = state == MID || state == LAST;
    mix_en     = state == MID;
    last_round = state == LAST;
    done       = state == LAST && cnt == 3'd0 && !abort;
    req_key    = state == INIT || (state == MID && cnt == MID_TOP) || (state == LAST && cnt == LAST_TOP);
    round_idx  = state == INIT ? (dec ? nr : 4'd0) :
                 state == MID  ? (dec ? nr - r : r) :
                 state == LAST ? (dec ? 4'd0 : nr) : 4'd0;
  end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed vector bench for aes_round_ctrl with default and single-cycle-round instances.
module tb_aes_round_ctrl;
  logic       clk = 1'b0, reset_n = 1'b0, abort = 1'b0, decrypt = 1'b0;
  logic [1:0] key_len = 2'b00;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic       busy0, done0, mux0, mix0, last0, req0;
  logic       busy1, done1, mux1, mix1, last1, req1;
  logic [3:0] idx0, idx1;
  int         checks = 0, failures = 0;
  always #5 clk = ~clk;
  aes_round_ctrl u0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .abort(abort), .decrypt(decrypt), .key_len(key_len),
    .busy(busy0), .done(done0), .mux_sel(mux0), .mix_en(mix0), .last_round(last0), .req_key(req0), .round_idx(idx0)
  );
  aes_round_ctrl #(.CYCLES_PER_ROUND(1), .LAST_CYCLES(1)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .abort(abort), .decrypt(decrypt), .key_len(key_len),
    .busy(busy1), .done(done1), .mux_sel(mux1), .mix_en(mix1), .last_round(last1), .req_key(req1), .round_idx(idx1)
  );
  typedef struct {
    bit         inst;
    bit         dec;
    logic [1:0] kl;
    int         nr, cpr, lc, len;
    bit         noise;
  } vec_t;
  vec_t tbl[8];
  // outputs packed as {busy, done, mux_sel, mix_en, last_round, req_key, round_idx}
  function automatic logic [9:0] obs(input bit i);
    return i ? {busy1, done1, mux1, mix1, last1, req1, idx1} : {busy0, done0, mux0, mix0, last0, req0, idx0};
  endfunction
  function automatic logic [9:0] model(input int k, input bit dec, input int nr, cpr, lc);
    int m = (nr - 1) * cpr;
    int j, r, p;
    if (k == 1) return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, dec ? 4'(nr) : 4'd0};
    if (k <= 1 + m) begin
      j = k - 2;
      r = j / cpr + 1;
      return {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'((j % cpr) == 0), dec ? 4'(nr - r) : 4'(r)};
    end
    p = k - 2 - m;
    return {1'b1, 1'(p == lc - 1), 1'b1, 1'b0, 1'b1, 1'(p == 0), dec ? 4'd0 : 4'(nr)};
  endfunction
  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask
  task automatic set_start(input bit i, input logic v);
    if (i) start1 = v;
    else start0 = v;
  endtask
  task automatic run(input bit i, input bit dec, input logic [1:0] kl, input int nr, cpr, lc, exp_len, input bit noise);
    int len = 0;
    decrypt = dec;
    key_len = kl;
    set_start(i, 1'b1);
    @(posedge clk);
    #1 set_start(i, 1'b0);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (!obs(i)[9]) break;
      len++;
      chk($sformatf("run_nr%0d_dec%0d_cyc%0d", nr, dec, k), obs(i), model(k, dec, nr, cpr, lc));
      if (noise) begin
        set_start(i, 1'b1);
        decrypt = ~decrypt;
        key_len = key_len + 2'd1;
      end
    end
    set_start(i, 1'b0);
    checks++;
    if (len != exp_len) begin
      failures++;
      $display("FAIL busy_len_nr%0d actual=%0d required=%0d", nr, len, exp_len);
    end
  endtask
  task automatic abort_at(input int c);
    decrypt = 1'b0;
    key_len = 2'b00;
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    for (int k = 1; k <= c; k++) begin
      @(negedge clk);
      if (k == c) begin
        abort = 1'b1;
        #1 chk($sformatf("abort_cyc%0d", c), obs(0), model(k, 1'b0, 10, 3, 2) & ~10'h100);
      end else chk($sformatf("pre_abort_cyc%0d", k), obs(0), model(k, 1'b0, 10, 3, 2));
    end
    @(negedge clk);
    chk($sformatf("after_abort%0d", c), obs(0), 10'd0);
    abort = 1'b0;
    @(negedge clk);
    chk($sformatf("idle_after_abort%0d", c), obs(0), 10'd0);
  endtask
  initial begin
    tbl = '{
      '{1'b0, 1'b0, 2'b00, 10, 3, 2, 30, 1'b0},
      '{1'b0, 1'b1, 2'b10, 14, 3, 2, 42, 1'b0},
      '{1'b0, 1'b0, 2'b01, 12, 3, 2, 36, 1'b1},
      '{1'b0, 1'b0, 2'b11, 10, 3, 2, 30, 1'b0},
      '{1'b0, 1'b1, 2'b00, 10, 3, 2, 30, 1'b1},
      '{1'b1, 1'b0, 2'b00, 10, 1, 1, 11, 1'b0},
      '{1'b1, 1'b1, 2'b01, 12, 1, 1, 13, 1'b1},
      '{1'b0, 1'b0, 2'b10, 14, 3, 2, 42, 1'b0}
    };
    @(negedge clk);
    chk("reset_u0", obs(0), 10'd0);
    chk("reset_u1", obs(1), 10'd0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 8; t++)
      run(tbl[t].inst, tbl[t].dec, tbl[t].kl, tbl[t].nr, tbl[t].cpr, tbl[t].lc, tbl[t].len, tbl[t].noise);
    start0 = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    chk("abort_blocks_start", obs(0), 10'd0);
    start0 = 1'b0;
    abort = 1'b0;
    abort_at(15);
    abort_at(30);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_reset_mid", obs(0), model(10, 1'b0, 10, 3, 2));
    #2 reset_n = 1'b0;
    #1 chk("async_reset", obs(0), 10'd0);
    @(negedge clk);
    chk("held_reset", obs(0), 10'd0);
    reset_n = 1'b1;
    @(negedge clk);
    run(1'b0, 1'b0, 2'b00, 10, 3, 2, 30, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Parametrised round-sequencing controller for the AES datapath. It replaces the fixed AES-128 decrypt-only sequencer. It supports encrypt and decrypt direction, AES-128/192/256 round counts, and configurable cycles per round. It also adds abort and busy/done handshakes. It drives the datapath mux select, MixColumns enable, key-schedule request and round-key index.

Parameters:
CYCLES_PER_ROUND, 3, clock cycles spent in each middle round; legal range 1..8.
LAST_CYCLES, 2, clock cycles spent in the final round (no MixColumns); legal range 1..8.

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request a new block; sampled only in IDLE
abort  input  1  terminate current operation
decrypt  input  1  0 = encrypt, 1 = decrypt; latched on start accept
key_len  input  2  00 = AES-128 (NR=10), 01 = AES-192 (NR=12), 10 = AES-256 (NR=14), 11 = reserved, treated as 00; latched on start accept
busy  output  1  high in INIT, MID and LAST
done  output  1  single-cycle pulse in the final cycle of LAST
mux_sel  output  1  0 = initial-data path (IDLE/INIT), 1 = round-feedback path (MID/LAST)
mix_en  output  1  MixColumns/InvMixColumns enable; high only in MID
last_round  output  1  high only in LAST
req_key  output  1  high in the first cycle of every round, including INIT
round_idx  output  4  round-key index for the current round

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, all counters cleared. Outputs busy=0, done=0, mux_sel=0, mix_en=0, last_round=0, req_key=0, round_idx=0.
- States: IDLE, INIT, MID, LAST. State and counters are registered; outputs are combinational decodes of the registered state.
- IDLE: start=1 and abort=0 at a rising edge: latch decrypt and NR, go to INIT. Otherwise stay in IDLE.
- INIT (1 cycle, AddRoundKey only): req_key=1, mux_sel=0, mix_en=0. round_idx=0 for encrypt, NR for decrypt. Next state MID; round counter r=1; cycle counter = CYCLES_PER_ROUND-1.
- MID (rounds r=1..NR-1):
  - Cycle counter counts down to 0. req_key=1 only when cycle counter = CYCLES_PER_ROUND-1.
  - round_idx = r for encrypt, NR-r for decrypt.
  - At cycle counter = 0: if r=NR-1, go to LAST with cycle counter = LAST_CYCLES-1. Otherwise r increments and the cycle counter reloads.
- LAST:
  - mix_en=0, last_round=1, mux_sel=1.
  - round_idx = NR for encrypt, 0 for decrypt. req_key=1 in the first LAST cycle.
  - done=1 when cycle counter = 0; next state is IDLE.
- Latency: busy lasts exactly 1 + (NR-1)*CYCLES_PER_ROUND + LAST_CYCLES cycles; done is in the last of them. Defaults give 30 cycles (128), 36 (192), 42 (256).
- With CYCLES_PER_ROUND=1 or LAST_CYCLES=1, req_key is high every cycle of that phase.
- Start handling:
  - start while busy is ignored; it is not queued.
  - start in the cycle done is high is ignored. A start on the following IDLE cycle is accepted, so the minimum gap is 1 idle cycle.
- decrypt/key_len changes while busy have no effect.
- abort=1 while busy: next state IDLE, counters cleared, done not asserted. This holds even if abort coincides with the final LAST cycle: abort wins and done is not pulsed.
- abort=1 in IDLE: start is suppressed that cycle.
- reset_n asserted mid-operation: immediate return to the reset values above, with no done pulse.
- Counter widths: round counter 4 bits; cycle counter 3 bits. No wrap is reachable within the legal parameter ranges.

Test Plan:
1. Defaults, encrypt, key_len=00, start pulse: busy high 30 cycles. round_idx sequence 0, 1×3 ... 9×3, 10×2. req_key high on cycles 1, 2, 5, ..., 26, 29. done on cycle 30 only; mix_en low in cycles 1 and 29-30.
2. Decrypt, key_len=10 (AES-256): busy 42 cycles. round_idx 14, then 13 down to 1 (3 cycles each), then 0 for 2 cycles. last_round high cycles 41-42; done on cycle 42.
3. key_len=01 then key_len=11 back-to-back, start re-asserted the cycle after done: the first run takes 36 busy cycles. The second start is accepted on the first IDLE cycle and takes 30 cycles (reserved decoded as AES-128). Toggling start while busy has no effect.
4. abort asserted in cycle 15 of an encrypt AES-128 run: busy=0 and round_idx=0 on the next cycle; no done pulse. abort on cycle 30 (the done cycle) also suppresses done.
5. reset_n pulsed low asynchronously mid-MID: all outputs return to reset values before the next clock edge. The next start runs a full 30-cycle operation.
6. CYCLES_PER_ROUND=1, LAST_CYCLES=1, encrypt, key_len=00: busy 11 cycles. req_key high every busy cycle; round_idx 0..10 consecutive; done on cycle 11.
